// File: rtl/reg_file_pkg.sv
// Shared definitions for the TRISC universal register file: MODE encodings and width.
package reg_file_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_INC  = 3'b100;
  localparam mode_t MODE_DEC  = 3'b101;
  localparam mode_t MODE_CLRR = 3'b110;
  localparam mode_t MODE_RSVD = 3'b111;

  // HOLD and the reserved code never execute, so they never touch COUT either.
  function automatic logic mode_is_op(input mode_t m);
    return (m != MODE_HOLD) && (m != MODE_RSVD);
  endfunction

endpackage

// File: rtl/univ_reg_next.sv
// Combinational next-value and next-carry for one universal register.
module univ_reg_next
  import reg_file_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]      r,
  input  logic [N-1:0]      d,
  input  logic              sin,
  input  logic [MODE_W-1:0] mode,
  output logic [N-1:0]      nxt,
  output logic              cout
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    nxt  = r;
    cout = 1'b0;
    case (mode)
      MODE_LOAD: nxt = d;
      MODE_SHL: begin
        nxt  = {r[N-2:0], sin};
        cout = r[N-1];
      end
      MODE_SHR: begin
        nxt  = {sin, r[N-1:1]};
        cout = r[0];
      end
      MODE_INC: begin
        nxt  = r + ONE;
        cout = &r;
      end
      MODE_DEC: begin
        nxt  = r - ONE;
        cout = ~|r;
      end
      MODE_CLRR: nxt = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file_univ.sv
// NREGS x N universal register file: one operate port, two combinational read ports, registered COUT.
// Define REG_FILE_BYPASS_EN to forward the pending write value onto QA/QB in the same cycle.
module reg_file_univ
  import reg_file_pkg::*;
#(
  parameter int N       = 8,
  parameter int NREGS   = 4,
  parameter int ZERO_R0 = 0,
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WE,
  input  logic [AW-1:0]     WADDR,
  input  logic [MODE_W-1:0] MODE,
  input  logic [N-1:0]      D,
  input  logic              SIN,
  input  logic [AW-1:0]     RADDR_A,
  input  logic [AW-1:0]     RADDR_B,
  output logic [N-1:0]      QA,
  output logic [N-1:0]      QB,
  output logic              COUT
);

  localparam bit HAS_ZERO_R0 = (ZERO_R0 != 0);

  logic [N-1:0] regs [NREGS];
  logic [N-1:0] cur;
  logic [N-1:0] nxt;
  logic         nxt_c;
  logic         waddr_ok;
  logic         exec;
  logic         wr_blocked;
  logic         cout_q;
  logic [N-1:0] qa_store;
  logic [N-1:0] qb_store;

  assign waddr_ok = int'(WADDR) < NREGS;
  assign exec     = WE && mode_is_op(MODE) && waddr_ok;
  // A protected R0 still executes (COUT moves) but its contents never change.
  assign wr_blocked = HAS_ZERO_R0 && (WADDR == '0);
  assign cur        = waddr_ok ? regs[WADDR] : '0;

  univ_reg_next #(.N(N)) u_next (
    .r    (cur),
    .d    (D),
    .sin  (SIN),
    .mode (MODE),
    .nxt  (nxt),
    .cout (nxt_c)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (exec && !wr_blocked) begin
      regs[WADDR] <= nxt;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)      cout_q <= 1'b0;
    else if (exec) cout_q <= nxt_c;
  end

  assign COUT = cout_q;

  // Out-of-range addresses and a protected R0 both read as zero.
  always_comb begin
    qa_store = '0;
    if (int'(RADDR_A) < NREGS && !(HAS_ZERO_R0 && RADDR_A == '0))
      qa_store = regs[RADDR_A];
  end

  always_comb begin
    qb_store = '0;
    if (int'(RADDR_B) < NREGS && !(HAS_ZERO_R0 && RADDR_B == '0))
      qb_store = regs[RADDR_B];
  end

`ifdef REG_FILE_BYPASS_EN
  logic [N-1:0] fwd_val;

  assign fwd_val = wr_blocked ? '0 : nxt;
  assign QA      = (exec && RADDR_A == WADDR) ? fwd_val : qa_store;
  assign QB      = (exec && RADDR_B == WADDR) ? fwd_val : qb_store;
`else
  assign QA = qa_store;
  assign QB = qb_store;
`endif

endmodule

// File: tb/tb_reg_file_univ.sv
// Directed bench for reg_file_univ: default instance plus a ZERO_R0=1, NREGS=3 instance on shared inputs.
module tb_reg_file_univ;
  import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       we;
  logic [1:0] waddr;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] qa, qb, qa_z, qb_z;
  logic       cout, cout_z;

  int vectors = 0;
  int errors  = 0;

  reg_file_univ #(.N(8), .NREGS(4), .ZERO_R0(0)) dut (
    .CLK(clk), .CLR(clr), .WE(we), .WADDR(waddr), .MODE(mode), .D(d), .SIN(sin),
    .RADDR_A(ra), .RADDR_B(rb), .QA(qa), .QB(qb), .COUT(cout)
  );

  reg_file_univ #(.N(8), .NREGS(3), .ZERO_R0(1)) dut_z (
    .CLK(clk), .CLR(clr), .WE(we), .WADDR(waddr), .MODE(mode), .D(d), .SIN(sin),
    .RADDR_A(ra), .RADDR_B(rb), .QA(qa_z), .QB(qb_z), .COUT(cout_z)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic op(input logic [1:0] a, input logic [2:0] m, input logic [7:0] dv, input logic s);
    we = 1'b1; waddr = a; mode = m; d = dv; sin = s;
    @(posedge clk); #1;
    we = 1'b0; mode = MODE_HOLD;
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (qa !== 8'h00) begin errors++; $display("FAIL rst_init_qa got %h want %h", qa, 8'h00); end
    vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_init_cout got %b want %b", cout, 1'b0); end
    @(posedge clk); #1; clr = 1'b1;
    op(2'd1, MODE_LOAD, 8'hA5, 1'b0);
    ra = 2'd1; rb = 2'd1; #1;
    vectors++; if (qa !== 8'hA5) begin errors++; $display("FAIL rst_load_a5 got %h want %h", qa, 8'hA5); end
    op(2'd1, MODE_SHL, 8'h00, 1'b0);
    #1;
    vectors++; if (qa !== 8'h4A) begin errors++; $display("FAIL rst_shl got %h want %h", qa, 8'h4A); end
    vectors++; if (cout !== 1'b1) begin errors++; $display("FAIL rst_shl_cout got %b want %b", cout, 1'b1); end
    // reset asserted while a LOAD is pending; no clock edge before the checks
    clr = 1'b0; we = 1'b1; waddr = 2'd1; mode = MODE_LOAD; d = 8'h77;
    #2;
    vectors++; if (qa !== 8'h00) begin errors++; $display("FAIL rst_async_qa got %h want %h", qa, 8'h00); end
    vectors++; if (qb !== 8'h00) begin errors++; $display("FAIL rst_async_qb got %h want %h", qb, 8'h00); end
    vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_async_cout got %b want %b", cout, 1'b0); end
    @(posedge clk); #1;
    we = 1'b0; mode = MODE_HOLD; clr = 1'b1;
    #1;
    vectors++; if (qa !== 8'h00) begin errors++; $display("FAIL rst_release_r1 got %h want %h", qa, 8'h00); end
    vectors++; if (cout_z !== 1'b0) begin errors++; $display("FAIL rst_z_cout got %b want %b", cout_z, 1'b0); end
  endtask

  task automatic test_load;
    op(2'd2, MODE_LOAD, 8'h3C, 1'b0);
    ra = 2'd2; rb = 2'd1; #1;
    vectors++; if (qa !== 8'h3C) begin errors++; $display("FAIL load_qa got %h want %h", qa, 8'h3C); end
    vectors++; if (qb !== 8'h00) begin errors++; $display("FAIL load_qb got %h want %h", qb, 8'h00); end
    vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL load_cout got %b want %b", cout, 1'b0); end
  endtask

  task automatic test_inc_dec;
    logic [2:0] m [4];
    logic [7:0] ev [4];
    logic       ec [4];
    m  = '{MODE_INC, MODE_INC, MODE_DEC, MODE_DEC};
    ev = '{8'h00, 8'h01, 8'h00, 8'hFF};
    ec = '{1'b1, 1'b0, 1'b0, 1'b1};
    op(2'd3, MODE_LOAD, 8'hFF, 1'b0);
    ra = 2'd3;
    for (int i = 0; i < 4; i++) begin
      op(2'd3, m[i], 8'h00, 1'b0);
      #1;
      vectors++; if (qa !== ev[i]) begin errors++; $display("FAIL incdec_%0d_q got %h want %h", i, qa, ev[i]); end
      vectors++; if (cout !== ec[i]) begin errors++; $display("FAIL incdec_%0d_cout got %b want %b", i, cout, ec[i]); end
    end
  endtask

  task automatic test_shift;
    logic [2:0] m [3];
    logic       s [3];
    logic [7:0] ev [3];
    logic       ec [3];
    m  = '{MODE_SHL, MODE_SHR, MODE_SHR};
    s  = '{1'b0, 1'b1, 1'b0};
    ev = '{8'h02, 8'h81, 8'h40};
    ec = '{1'b1, 1'b0, 1'b1};
    op(2'd1, MODE_LOAD, 8'h81, 1'b0);
    ra = 2'd1;
    for (int i = 0; i < 3; i++) begin
      op(2'd1, m[i], 8'h00, s[i]);
      #1;
      vectors++; if (qa !== ev[i]) begin errors++; $display("FAIL shift_%0d_q got %h want %h", i, qa, ev[i]); end
      vectors++; if (cout !== ec[i]) begin errors++; $display("FAIL shift_%0d_cout got %b want %b", i, cout, ec[i]); end
    end
  endtask

  task automatic test_guard;
    op(2'd1, MODE_LOAD, 8'h00, 1'b0);
    op(2'd0, MODE_DEC, 8'h00, 1'b0);
    ra = 2'd0; #1;
    vectors++; if (qa !== 8'hFF) begin errors++; $display("FAIL guard_r0_dec got %h want %h", qa, 8'hFF); end
    vectors++; if (qa_z !== 8'h00) begin errors++; $display("FAIL guard_z_r0 got %h want %h", qa_z, 8'h00); end
    vectors++; if (cout_z !== 1'b1) begin errors++; $display("FAIL guard_z_cout got %b want %b", cout_z, 1'b1); end
    // WE low with a real mode, then WE high with the reserved code: nothing may move
    we = 1'b0; waddr = 2'd2; mode = MODE_INC;
    @(posedge clk); #1;
    we = 1'b1; mode = MODE_RSVD;
    @(posedge clk); #1;
    we = 1'b0; mode = MODE_HOLD;
    ra = 2'd2; #1;
    vectors++; if (qa !== 8'h3C) begin errors++; $display("FAIL guard_hold_q got %h want %h", qa, 8'h3C); end
    vectors++; if (cout !== 1'b1) begin errors++; $display("FAIL guard_hold_cout got %b want %b", cout, 1'b1); end
    // WADDR=3 is out of range for the three-register instance
    op(2'd3, MODE_LOAD, 8'hAA, 1'b0);
    ra = 2'd3; #1;
    vectors++; if (qa !== 8'hAA) begin errors++; $display("FAIL guard_r3_load got %h want %h", qa, 8'hAA); end
    vectors++; if (cout_z !== 1'b1) begin errors++; $display("FAIL guard_oor_cout got %b want %b", cout_z, 1'b1); end
    vectors++; if (qa_z !== 8'h00) begin errors++; $display("FAIL guard_oor_read got %h want %h", qa_z, 8'h00); end
    op(2'd2, MODE_CLRR, 8'h00, 1'b0);
    ra = 2'd2; #1;
    vectors++; if (qa !== 8'h00) begin errors++; $display("FAIL guard_clrr_q got %h want %h", qa, 8'h00); end
    vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL guard_clrr_cout got %b want %b", cout, 1'b0); end
  endtask

  task automatic test_bypass;
    logic [7:0] exp_v;
    ra = 2'd1; rb = 2'd1;
    we = 1'b1; waddr = 2'd1; mode = MODE_LOAD; d = 8'h55; sin = 1'b0;
    #1;
    exp_v = BYP ? 8'h55 : 8'h00;
    vectors++; if (qa !== exp_v) begin errors++; $display("FAIL bypass_load_qa got %h want %h", qa, exp_v); end
    vectors++; if (qb !== exp_v) begin errors++; $display("FAIL bypass_load_qb got %h want %h", qb, exp_v); end
    @(posedge clk); #1;
    mode = MODE_INC;
    #1;
    exp_v = BYP ? 8'h56 : 8'h55;
    vectors++; if (qa !== exp_v) begin errors++; $display("FAIL bypass_inc_qa got %h want %h", qa, exp_v); end
    vectors++; if (cout !== 1'b0) begin errors++; $display("FAIL bypass_inc_cout got %b want %b", cout, 1'b0); end
    @(posedge clk); #1;
    we = 1'b0; mode = MODE_HOLD;
    #1;
    vectors++; if (qa !== 8'h56) begin errors++; $display("FAIL bypass_after got %h want %h", qa, 8'h56); end
  endtask

  initial begin
    clr = 1'b0; we = 1'b0; waddr = '0; mode = MODE_HOLD; d = '0; sin = 1'b0;
    ra = 2'd1; rb = 2'd2;
    test_reset();
    test_load();
    test_inc_dec();
    test_shift();
    test_guard();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
